regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file for the ID stage. Next generation of the
//  2R/1W file: configurable width, depth, read/write port count, x0 hardwired to zero,
//  write-to-read bypass across all ports, and a sequential clear engine that zeroes the
//  array after reset or on request.
// PARAMETERS
//  DATA_WIDTH  64  register width in bits
//  ADDR_WIDTH  5   register address width; DEPTH = 2**ADDR_WIDTH entries
//  NUM_RD      2   number of read ports
//  NUM_WR      2   number of write ports; higher port index = younger instruction
// PORTS
//  clk      in   1                     clock, rising edge
//  reset    in   1                     asynchronous, active-high
//  clr_req  in   1                     pulse: restart the clear sequence
//  busy     out  1                     1 while the clear engine runs
//  we       in   NUM_WR                per-port write enable
//  waddr    in   NUM_WR*ADDR_WIDTH     write addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//  wdata    in   NUM_WR*DATA_WIDTH     write data, packed the same way
//  raddr    in   NUM_RD*ADDR_WIDTH     read addresses, packed
//  rdata    out  NUM_RD*DATA_WIDTH     read data, combinational, packed
//  dbg_addr in   ADDR_WIDTH            debug read address
//  dbg_data out  DATA_WIDTH            raw array contents at dbg_addr, no bypass
// BEHAVIOUR
//  - Reset: async; while reset=1 FSM=CLEAR, clr_idx=1, busy=1; all rdata and dbg_data read 0.
//  - FSM states IDLE, CLEAR. In CLEAR, each posedge writes 0 to entry clr_idx and increments
//    clr_idx. The edge that clears entry DEPTH-1 moves the FSM to IDLE; busy drops on that edge.
//    busy is high for exactly DEPTH-1 cycles after reset deasserts (31 with defaults).
//  - clr_req=1 in IDLE: next edge enters CLEAR with clr_idx=1; user writes that cycle are dropped.
//    clr_req=1 in CLEAR: clr_idx restarts at 1 on the next edge.
//  - busy=1: all we are ignored; every rdata reads 0; dbg_data shows raw array contents.
//  - Writes (IDLE, no clr_req): on posedge, each port with we=1 and waddr!=0 writes wdata.
//    Writes to x0 are discarded. When two ports write the same address in one cycle, the
//    highest-index port wins.
//  - Reads: rdata[r] = 0 if raddr[r]==0 or busy; else if any port p has we=1 and
//    waddr[p]==raddr[r], the wdata of the highest such p (same-cycle bypass); else array[raddr[r]].
//  - Read latency: 0 cycles (combinational). Write is visible from the array one edge later,
//    and via bypass in the same cycle.
//  - Entry 0 never stores a nonzero value; dbg_addr=0 reads 0.
//  - Reset asserted mid-clear or mid-write: state returns immediately to CLEAR, clr_idx=1.
//    Array contents are undefined until the clear completes.
//  - Array is not reset directly; zeroing is done only by the clear engine.
// TESTING
//  1 Reset release: busy high 31 cycles then 0; dbg_data for addr 1..31 = 0;
//    we=1 during busy -> no effect.
//  2 Write/read: port0 writes x5=0x1234 -> rdata0(raddr=5)=0x1234 in the same cycle
//    (bypass) and after the edge (array).
//  3 Conflict: port0 x7=0xAAAA, port1 x7=0xBBBB in one cycle -> rdata=0xBBBB, dbg x7=0xBBBB.
//  4 x0: write x0=0xFFFF -> rdata(raddr=0)=0, dbg_data(0)=0.
//  5 clr_req in IDLE with x3=9: busy high 31 cycles, then x3 reads 0;
//    clr_req again at cycle 10 of clear -> busy lasts 31 more cycles.
//  6 Reset mid-operation: assert reset during writes -> rdata=0 immediately;
//    after release busy=1 for 31 cycles.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: write ports, read ports,
// debug read port and the clear-engine handshake.
interface regfile_mp_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
);
    logic                         clr_req;
    logic                         busy;
    logic [NUM_WR-1:0]            we;
    logic [NUM_WR*ADDR_WIDTH-1:0] waddr;
    logic [NUM_WR*DATA_WIDTH-1:0] wdata;
    logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
    logic [NUM_RD*DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0]        dbg_addr;
    logic [DATA_WIDTH-1:0]        dbg_data;

    modport master (
        output clr_req, we, waddr, wdata, raddr, dbg_addr,
        input  busy, rdata, dbg_data
    );

    modport slave (
        input  clr_req, we, waddr, wdata, raddr, dbg_addr,
        output busy, rdata, dbg_data
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file for the ID stage: x0 hardwired to zero,
// same-cycle write-to-read bypass, and a sequential clear engine.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | normal operation, user writes accepted, reads served
//  CLEAR | clear engine zeroes entry clr_idx each edge; busy=1, rdata=0
module regfile_mp #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
) (
    input  logic       clk,
    input  logic       reset,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_idx_q, clr_idx_d;
    logic                    clr_wr;
    logic                    user_wr;
    logic                    busy;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign busy     = (state_q == CLEAR);
    assign bus.busy = busy;

    // State register and clear index; reset restarts the clear from entry 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= FIRST_IDX;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next-state logic; a clear request always wins over user writes.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_wr    = 1'b0;
        user_wr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d   = CLEAR;
                    clr_idx_d = FIRST_IDX;
                end else begin
                    user_wr = 1'b1;
                end
            end
            CLEAR: begin
                clr_wr = 1'b1;
                if (bus.clr_req) begin
                    clr_idx_d = FIRST_IDX;
                end else begin
                    clr_idx_d = clr_idx_q + FIRST_IDX;
                    if (clr_idx_q == LAST_IDX)
                        state_d = IDLE;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_idx_d = FIRST_IDX;
            end
        endcase
    end

    // Array update: clear engine or user ports; later ports overwrite earlier
    // ones so the youngest instruction wins an address conflict. x0 is never written.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[clr_idx_q] <= '0;
        end else if (user_wr) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (bus.we[p] && (bus.waddr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0))
                    mem[bus.waddr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wdata[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Combinational read ports with bypass from the highest matching write port.
    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rv;
        bus.rdata = '0;
        ra        = '0;
        rv        = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            ra = bus.raddr[r*ADDR_WIDTH +: ADDR_WIDTH];
            rv = '0;
            if (!busy && (ra != '0)) begin
                rv = mem[ra];
                for (int p = 0; p < NUM_WR; p++) begin
                    if (bus.we[p] && (bus.waddr[p*ADDR_WIDTH +: ADDR_WIDTH] == ra))
                        rv = bus.wdata[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            bus.rdata[r*DATA_WIDTH +: DATA_WIDTH] = rv;
        end
    end

    // Debug port shows raw array contents; the array is not reset, so mask it
    // while reset is held and for x0.
    assign bus.dbg_data = (reset || (bus.dbg_addr == '0)) ? '0 : mem[bus.dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_regfile_mp;
    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: register contents and remaining busy cycles.
    logic [DW-1:0] mm [DEPTH];
    int busy_left;
    int busy_seen;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_zero();
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int r);
        logic [AW-1:0] ra;
        logic [DW-1:0] v;
        ra = bus.raddr[r*AW +: AW];
        if (busy_left > 0 || ra == 0) return '0;
        v = mm[ra];
        for (int p = 0; p < NW; p++)
            if (bus.we[p] && bus.waddr[p*AW +: AW] == ra) v = bus.wdata[p*DW +: DW];
        return v;
    endfunction

    task automatic check_outputs();
        chk("busy", {63'd0, bus.busy}, {63'd0, busy_left > 0});
        if (bus.busy) busy_seen++;
        for (int r = 0; r < NR; r++)
            chk($sformatf("rdata%0d", r), bus.rdata[r*DW +: DW], exp_rd(r));
        if (busy_left == 0)
            chk("dbg", bus.dbg_data, (bus.dbg_addr == 0) ? '0 : mm[bus.dbg_addr]);
    endtask

    task automatic model_edge();
        if (busy_left > 0) begin
            if (bus.clr_req) busy_left = DEPTH - 1;
            else begin
                busy_left--;
                if (busy_left == 0) model_zero();
            end
        end else if (bus.clr_req) begin
            busy_left = DEPTH - 1;
        end else begin
            for (int p = 0; p < NW; p++)
                if (bus.we[p] && bus.waddr[p*AW +: AW] != 0)
                    mm[bus.waddr[p*AW +: AW]] = bus.wdata[p*DW +: DW];
        end
    endtask

    // Inputs are driven at the negedge; check 1 time unit later, then advance.
    task automatic cycle();
        #1 check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.clr_req  = 1'b0;
        bus.we       = '0;
        bus.waddr    = '0;
        bus.wdata    = '0;
        bus.raddr    = '0;
        bus.dbg_addr = '0;
    endtask

    task automatic rand_inputs(input int clr_pct);
        bus.clr_req = ($urandom_range(0, 99) < clr_pct);
        bus.we      = NW'($urandom);
        for (int p = 0; p < NW; p++) begin
            bus.waddr[p*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            bus.wdata[p*DW +: DW] = {$urandom, $urandom};
        end
        for (int r = 0; r < NR; r++)
            bus.raddr[r*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
        bus.dbg_addr = AW'($urandom);
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.we[p]             = 1'b1;
        bus.waddr[p*AW +: AW] = a;
        bus.wdata[p*DW +: DW] = d;
    endtask

    // Assert reset (already at a negedge or mid-cycle), check the held state, release at a negedge.
    task automatic do_reset();
        reset        = 1'b1;
        bus.raddr    = {AW'(5), AW'(3)};
        bus.dbg_addr = AW'(4);
        #1;
        chk("rst_busy",  {63'd0, bus.busy}, 64'd1);
        chk("rst_rdata0", bus.rdata[0 +: DW], '0);
        chk("rst_rdata1", bus.rdata[DW +: DW], '0);
        chk("rst_dbg",   bus.dbg_data, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        busy_left = DEPTH - 1;
        model_zero();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        busy_left = DEPTH - 1;
        model_zero();
        @(negedge clk);

        // 1: reset release, writes during busy ignored, busy length, array cleared
        do_reset();
        busy_seen = 0;
        repeat (DEPTH - 1) begin
            rand_inputs(0);
            bus.we = '1;
            cycle();
        end
        idle_inputs();
        for (int a = 0; a < DEPTH; a++) begin
            bus.dbg_addr = AW'(a);
            cycle();
        end
        chk("t1_busy_len", 64'(busy_seen), 64'(DEPTH - 1));

        // 2: write x5 with bypass, then from the array
        idle_inputs();
        set_wr(0, AW'(5), 64'h1234);
        bus.raddr[0 +: AW] = AW'(5);
        #1 chk("t2_bypass", bus.rdata[0 +: DW], 64'h1234);
        cycle();
        idle_inputs();
        bus.raddr[0 +: AW] = AW'(5);
        #1 chk("t2_array", bus.rdata[0 +: DW], 64'h1234);
        cycle();

        // 3: same-address conflict, higher port wins
        set_wr(0, AW'(7), 64'hAAAA);
        set_wr(1, AW'(7), 64'hBBBB);
        bus.raddr[0 +: AW] = AW'(7);
        #1 chk("t3_bypass", bus.rdata[0 +: DW], 64'hBBBB);
        cycle();
        idle_inputs();
        bus.dbg_addr = AW'(7);
        #1 chk("t3_dbg", bus.dbg_data, 64'hBBBB);
        cycle();

        // 4: x0 stays zero
        set_wr(0, AW'(0), 64'hFFFF);
        bus.raddr[0 +: AW] = AW'(0);
        #1 chk("t4_bypass_x0", bus.rdata[0 +: DW], '0);
        cycle();
        idle_inputs();
        #1 chk("t4_dbg_x0", bus.dbg_data, '0);
        cycle();

        // 5: clr_req in IDLE, then a restart at cycle 10 of the clear
        set_wr(0, AW'(3), 64'd9);
        cycle();
        idle_inputs();
        bus.raddr[0 +: AW] = AW'(3);
        #1 chk("t5_x3_set", bus.rdata[0 +: DW], 64'd9);
        bus.clr_req = 1'b1;
        cycle();
        bus.clr_req = 1'b0;
        repeat (10) cycle();
        bus.clr_req = 1'b1;
        cycle();
        bus.clr_req = 1'b0;
        busy_seen = 0;
        repeat (DEPTH + 4) cycle();
        chk("t5_busy_len", 64'(busy_seen), 64'(DEPTH - 1));
        #1 chk("t5_x3_zero", bus.rdata[0 +: DW], '0);
        cycle();

        // 6: reset in the middle of a write cycle
        repeat (5) begin
            rand_inputs(0);
            cycle();
        end
        rand_inputs(0);
        #3;
        do_reset();
        idle_inputs();
        busy_seen = 0;
        repeat (DEPTH + 4) cycle();
        chk("t6_busy_len", 64'(busy_seen), 64'(DEPTH - 1));

        // Randomized traffic with occasional clear requests
        repeat (2000) begin
            rand_inputs(2);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
